riscv_data_mem: RTL and testbench
=================================

# riscv_data_mem

Word-organised data memory placed directly downstream of the load/store unit on the core data port. It accepts one byte-enabled read or write at a time over the req/we/be/addr/wd bus and inserts a programmable number of wait states. It then acknowledges with a one-cycle ready pulse, so the LSU's stall logic releases the core exactly once per access. Read data is always a full aligned word; lane extraction and sign extension stay in the LSU.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, at least 2.
- LATENCY, 2: cycles from request capture to the ready pulse; legal range 1..15.
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- mem_req_i  in  1  access request; the master holds it high until it samples mem_ready_o high.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_be_i  in  4  byte-lane write enables; bit n enables wd[8n+7:8n]; ignored on reads.
- mem_addr_i  in  32  byte address; word index = addr[31:2], and addr[1:0] is ignored.
- mem_wd_i  in  32  write data, already lane-replicated by the LSU.
- mem_rd_o  out  32  read data, registered; valid while mem_ready_o = 1.
- mem_ready_o  out  1  one-cycle completion pulse.

## Operation
- State machine with three states:
  - IDLE: ready = 0. If mem_req_i = 1, capture we, be, word index, and wd into registers, load the wait counter with LATENCY-1, then go to BUSY if LATENCY > 1, else go to RESP.
  - BUSY: decrement the counter each cycle. When the counter equals 1, go to RESP on the next edge. Inputs are not sampled in BUSY.
  - RESP: ready = 1 for exactly this cycle. The access is performed on the edge that enters RESP:
    - Write: update only the enabled lanes.
    - Read: load the addressed word into the mem_rd_o register.
  - RESP always returns to IDLE, even if mem_req_i is still high. The still-high req belongs to the acknowledged access and must not start a new one.
- Out-of-range accesses (word index ≥ DEPTH):
  - Write is dropped.
  - Read returns 32'h0000_0000.
  - The access is still acknowledged with normal timing.
- A write with be = 4'b0000 leaves memory unchanged and is still acknowledged.
- If mem_req_i drops while in BUSY (protocol violation), the captured access still completes and still produces its ready pulse.
- mem_rd_o holds its last loaded value outside RESP. Writes do not change mem_rd_o.
- Memory array: no reset, contents undefined at power-up. Infer it as a synchronous single-port RAM.

## Timing
- Reset values:
  - state = IDLE
  - mem_ready_o = 0
  - mem_rd_o = 32'h0
  - counter = 0
  - captured request registers = 0
- Reset asserted mid-access: the machine returns to IDLE immediately (asynchronous) and no ready pulse is issued. A write that had not yet reached RESP is not committed. The master re-issues the access after reset.
- Latency: request seen in IDLE on edge t0, mem_ready_o = 1 in cycle t0+LATENCY.
  - The LSU stalls on the first request cycle by construction, so LATENCY ≥ 1 always satisfies its "stalled last cycle and ready now" release condition.
- Throughput: one access per LATENCY+1 cycles. The cycle after RESP is IDLE and can capture a new request on that same edge.
- Back-to-back rule: the LSU deasserts stall in the RESP cycle and may present the next access in the following cycle. That access is captured there with no extra idle cycle.
- mem_rd_o and mem_ready_o come straight from registers (no combinational input-to-output path).

## Test plan
- Reset check (LATENCY=2): assert rst_i mid-cycle -> mem_ready_o=0 and mem_rd_o=0 immediately, with no clock edge needed.
- Word write then read (LATENCY=2):
  - Write addr 0x10, wd 0xDEADBEEF, be 1111 -> ready high exactly 2 cycles after capture, for one cycle.
  - Read addr 0x10 -> mem_rd_o = 0xDEADBEEF with ready.
- Byte-lane merge:
  - Write 0x11223344 to addr 0x20 with be 1111.
  - Write wd 0xAAAAAAAA with be 0100.
  - Read -> 0x11AA3344.
  - Repeat with a halfword write, wd 0x5555_5555, be 1100 -> 0x55553344.
- Latency sweep: LATENCY = 1, 3, 15 -> ready exactly LATENCY cycles after capture. Held req during RESP produces exactly one pulse per access. Back-to-back accesses are spaced LATENCY+1 cycles.
- Boundary cases with DEPTH = 1024:
  - Write to word 1023 (addr 0xFFC), then read it back -> data returned.
  - Write to addr 0x1000 -> acknowledged, memory unchanged.
  - Read of addr 0x1000 -> 0x0.
  - be=0000 write -> contents unchanged, ready pulsed.
- Reset mid-access: start a write to 0x30 (LATENCY=4) and assert rst_i during BUSY -> no ready pulse, and a subsequent read of 0x30 returns the prior contents.
- Integration with the LSU: sb/sh/sw/lb/lbu/lh/lhu/lw sequence -> core stall lasts exactly LATENCY cycles per access and sign/zero-extended results are correct.

Source files
------------

// File: rtl/riscv_data_mem.sv
// Word-organised data memory for the core data port: one byte-enabled access at a time,
// LATENCY cycles from capture to a single-cycle ready pulse, full aligned word on reads.
module riscv_data_mem #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [29:0] idx_q;
  logic [31:0] wd_q;

  logic        acc_fire, acc_we, acc_in_range;
  logic [3:0]  acc_be;
  logic [29:0] acc_idx;
  logic [31:0] acc_wd;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;
  logic        ready_q;

  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_req_i) begin
        cnt_q <= 4'(LATENCY - 1);
        we_q  <= mem_we_i;
        be_q  <= mem_be_i;
        idx_q <= mem_addr_i[31:2];
        wd_q  <= mem_wd_i;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req_i) state_d = (LATENCY > 1) ? BUSY : RESP;
      BUSY:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access happens on the edge entering RESP; with LATENCY=1 that is the capture
  // edge itself, so the live bus is used instead of the not-yet-loaded capture registers.
  always_comb begin
    acc_fire     = (state_d == RESP) && !rst_i;
    acc_we       = (state_q == IDLE) ? mem_we_i          : we_q;
    acc_be       = (state_q == IDLE) ? mem_be_i          : be_q;
    acc_idx      = (state_q == IDLE) ? mem_addr_i[31:2]  : idx_q;
    acc_wd       = (state_q == IDLE) ? mem_wd_i          : wd_q;
    acc_in_range = ({2'b00, acc_idx} < 32'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (acc_fire && acc_we && acc_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx[AW-1:0]][8*i +: 8] <= acc_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      ready_q <= acc_fire;
      if (acc_fire && !acc_we) rd_q <= acc_in_range ? mem[acc_idx[AW-1:0]] : '0;
    end
  end

  assign mem_rd_o    = rd_q;
  assign mem_ready_o = ready_q;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Self-checking bench for riscv_data_mem: one instance per latency under test, a directed
// vector table, multi-cycle corner sequences and a randomized run against a word-array model.
module tb_riscv_data_mem;

  localparam int NI = 5;
  localparam logic [4:0][3:0] LATS = {4'd15, 4'd4, 4'd3, 4'd2, 4'd1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [NI];
  logic        we  [NI];
  logic [3:0]  be  [NI];
  logic [31:0] addr[NI];
  logic [31:0] wd  [NI];
  logic [31:0] rd  [NI];
  logic        rdy [NI];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    riscv_data_mem #(.DEPTH(1024), .LATENCY(LATS[g])) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .mem_req_i  (req[g]),
      .mem_we_i   (we[g]),
      .mem_be_i   (be[g]),
      .mem_addr_i (addr[g]),
      .mem_wd_i   (wd[g]),
      .mem_rd_o   (rd[g]),
      .mem_ready_o(rdy[g])
    );
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  function automatic int lat_of(input int k);
    return int'(LATS[k]);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // One complete access: drive, wait (bounded) for ready, release, confirm single-cycle pulse.
  task automatic access(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output int lat);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wd[k] = d;
    lat = 0;
    r   = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy[k]) begin
        lat = i;
        r   = rd[k];
        break;
      end
    end
    @(negedge clk);
    req[k] = 1'b0; wd[k] = $urandom;
    @(posedge clk); #1;
    check("pulse_width", 32'(rdy[k]), 32'h0);
  endtask

  task automatic held_req(input int k);
    int l;
    int pulses;
    int extra;
    int pos[3];
    l = lat_of(k);
    pulses = 0;
    extra = 0;
    pos = '{0, 0, 0};
    @(negedge clk);
    req[k] = 1'b1; we[k] = 1'b0; be[k] = 4'hF; addr[k] = 32'h40;
    for (int n = 1; n <= 80 && pulses < 3; n++) begin
      @(posedge clk); #1;
      if (rdy[k]) begin
        pos[pulses] = n;
        pulses++;
      end
    end
    @(negedge clk);
    req[k] = 1'b0;
    for (int j = 0; j < 3; j++) check("held_pulse_pos", 32'(pos[j]), 32'(l + j * (l + 1)));
    for (int n = 0; n < l + 3; n++) begin
      @(posedge clk); #1;
      if (rdy[k]) extra++;
    end
    check("held_extra_pulse", 32'(extra), 32'h0);
  endtask

  task automatic rand_test(input int k);
    logic [31:0] model [16];
    logic [31:0] r, last, a, d, exp;
    logic [3:0]  b;
    logic        w, oor;
    int          lat, i;
    for (int j = 0; j < 16; j++) begin
      model[j] = $urandom;
      access(k, 1'b1, 4'hF, 32'((64 + j) * 4), model[j], r, lat);
      check("rand_init_lat", 32'(lat), 32'(lat_of(k)));
    end
    access(k, 1'b0, 4'h0, 32'(64 * 4), 32'h0, r, lat);
    check("rand_first_rd", r, model[0]);
    last = model[0];
    for (int n = 0; n < 40; n++) begin
      i   = $urandom_range(0, 15);
      oor = ($urandom_range(0, 5) == 0);
      a   = 32'((64 + i) * 4) | 32'($urandom_range(0, 3));
      if (oor) a = a | 32'h0000_1000;
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom);
      d = $urandom;
      access(k, w, b, a, d, r, lat);
      check("rand_lat", 32'(lat), 32'(lat_of(k)));
      if (w) begin
        if (!oor)
          for (int ln = 0; ln < 4; ln++)
            if (b[ln]) model[i][8*ln +: 8] = d[8*ln +: 8];
        exp = last;
      end else begin
        exp  = oor ? 32'h0 : model[i];
        last = exp;
      end
      check(w ? "rand_rd_after_wr" : "rand_rd", r, exp);
    end
  endtask

  vec_t        tbl [16];
  logic [31:0] r, last;
  int          lat, extra;

  initial begin
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = '0; addr[k] = '0; wd[k] = '0;
    end
    tbl[0]  = '{1'b1, 4'hF, 32'h0000, 32'h0BADC0DE, 32'h0};
    tbl[1]  = '{1'b1, 4'hF, 32'h0010, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b0, 4'h0, 32'h0010, 32'h0,        32'hDEADBEEF};
    tbl[3]  = '{1'b0, 4'h0, 32'h0013, 32'h0,        32'hDEADBEEF};
    tbl[4]  = '{1'b1, 4'hF, 32'h0020, 32'h11223344, 32'h0};
    tbl[5]  = '{1'b1, 4'h4, 32'h0020, 32'hAAAAAAAA, 32'h0};
    tbl[6]  = '{1'b0, 4'h0, 32'h0020, 32'h0,        32'h11AA3344};
    tbl[7]  = '{1'b1, 4'hC, 32'h0020, 32'h55555555, 32'h0};
    tbl[8]  = '{1'b0, 4'h0, 32'h0020, 32'h0,        32'h55553344};
    tbl[9]  = '{1'b1, 4'hF, 32'h0FFC, 32'hCAFEF00D, 32'h0};
    tbl[10] = '{1'b0, 4'h0, 32'h0FFC, 32'h0,        32'hCAFEF00D};
    tbl[11] = '{1'b1, 4'hF, 32'h1000, 32'h12345678, 32'h0};
    tbl[12] = '{1'b0, 4'h0, 32'h1000, 32'h0,        32'h0};
    tbl[13] = '{1'b0, 4'h0, 32'h0000, 32'h0,        32'h0BADC0DE};
    tbl[14] = '{1'b1, 4'h0, 32'h0010, 32'hFFFFFFFF, 32'h0};
    tbl[15] = '{1'b0, 4'h0, 32'h0010, 32'h0,        32'hDEADBEEF};

    #12;
    for (int k = 0; k < NI; k++) begin
      check("reset_ready", 32'(rdy[k]), 32'h0);
      check("reset_rd", rd[k], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed table on LATENCY=2; writes must leave the read register untouched.
    last = 32'h0;
    for (int v = 0; v < 16; v++) begin
      access(1, tbl[v].we, tbl[v].be, tbl[v].addr, tbl[v].wd, r, lat);
      check("tbl_lat", 32'(lat), 32'd2);
      if (!tbl[v].we) last = tbl[v].rd;
      check(tbl[v].we ? "tbl_rd_after_wr" : "tbl_rd", r, last);
    end

    // Asynchronous reset while the ready pulse is high.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rdy[1]) begin
        lat = i;
        break;
      end
    end
    check("rst_pre_lat", 32'(lat), 32'd2);
    check("rst_pre_rd", rd[1], 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(rdy[1]), 32'h0);
    check("async_rst_rd", rd[1], 32'h0);
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Latency sweep and held-request behaviour for every instance.
    for (int k = 0; k < NI; k++) begin
      access(k, 1'b1, 4'hF, 32'h40, 32'hA5A50000 | 32'(k), r, lat);
      check("sweep_wr_lat", 32'(lat), 32'(lat_of(k)));
      access(k, 1'b0, 4'h0, 32'h40, 32'h0, r, lat);
      check("sweep_rd_lat", 32'(lat), 32'(lat_of(k)));
      check("sweep_rd", r, 32'hA5A50000 | 32'(k));
      held_req(k);
    end

    // Reset during BUSY on LATENCY=4: the in-flight write must not commit.
    access(3, 1'b1, 4'hF, 32'h30, 32'h600DF00D, r, lat);
    @(negedge clk);
    req[3] = 1'b1; we[3] = 1'b1; be[3] = 4'hF; addr[3] = 32'h30; wd[3] = 32'hBAD0BAD0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", 32'(rdy[3]), 32'h0);
    extra = 0;
    @(negedge clk);
    req[3] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (rdy[3]) extra++;
    end
    check("midrst_no_pulse", 32'(extra), 32'h0);
    access(3, 1'b0, 4'h0, 32'h30, 32'h0, r, lat);
    check("midrst_rd_lat", 32'(lat), 32'd4);
    check("midrst_rd", r, 32'h600DF00D);

    rand_test(0);
    rand_test(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
